// File: rtl/riscv_pkg.sv
// Shared constants and types for the front end of the pipelined cache CPU.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        LOOKUP = 1'b0,
        REFILL = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped, one-word-per-line instruction cache storage.
// Combinational read port, one synchronous write port.
module icache_array #(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // NOTE: tag/data storage has no reset; the cleared valid bits make its
    // contents unobservable, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, I-cache lookup, req/ack refill and the IF/ID register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       CACHE_LINES   = 16,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = DEFAULT_RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_i,
    input  logic                     redirect_i,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
    output logic                     mem_req_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    input  logic                     mem_ack_i,
    input  logic [31:0]              mem_rdata_i,
    output logic [31:0]              instr_o,
    output logic [ADDRESS_WIDTH-1:0] pc_o,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_o,
    output logic                     valid_o
);

    localparam int AW    = ADDRESS_WIDTH;
    localparam int IDX   = $clog2(CACHE_LINES);
    localparam int TAG_W = AW - IDX - 2;
    localparam logic [AW-1:0] PC_STEP    = AW'(4);
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

    fetch_state_t state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   instr_q, instr_d;
    logic [AW-1:0] pc_out_q, pc_out_d;
    logic [AW-1:0] pc4_q, pc4_d;
    logic          valid_q, valid_d;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit;
    logic             fill;
    logic             load_ifid;
    logic             take_word;

    icache_array #(
        .LINES (CACHE_LINES),
        .IDX_W (IDX),
        .TAG_W (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (pc_q[IDX+1:2]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (fill),
        .wr_idx_i   (mem_addr_q[IDX+1:2]),
        .wr_tag_i   (mem_addr_q[AW-1:IDX+2]),
        .wr_data_i  (mem_rdata_i)
    );

    assign hit = rd_valid && (rd_tag == pc_q[AW-1:IDX+2]);

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        fill       = 1'b0;
        load_ifid  = !stall_i;
        take_word  = 1'b0;

        case (state_q)
            LOOKUP: begin
                take_word = hit;
                if (hit) begin
                    if (!stall_i) pc_d = pc_q + PC_STEP;
                end else begin
                    state_d    = REFILL;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {pc_q[AW-1:2], 2'b00};
                end
            end
            REFILL: begin
                // The request is never abandoned; a redirect only moves the PC.
                if (mem_ack_i) begin
                    fill      = 1'b1;
                    state_d   = LOOKUP;
                    mem_req_d = 1'b0;
                end
            end
            default: state_d = LOOKUP;
        endcase

        if (redirect_i) begin
            pc_d      = redirect_pc_i & ALIGN_MASK;
            load_ifid = 1'b1;
            take_word = 1'b0;
        end

        if (load_ifid) begin
            pc_out_d = pc_q;
            pc4_d    = pc_q + PC_STEP;
            valid_d  = take_word;
            instr_d  = take_word ? rd_data : NOP_INSTR;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOOKUP;
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            instr_q    <= NOP_INSTR;
            pc_out_q   <= '0;
            pc4_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign instr_o    = instr_q;
    assign pc_o       = pc_out_q;
    assign pc_plus4_o = pc4_q;
    assign valid_o    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a cycle model of the fetch rules plus
// hand-computed checkpoints for cold start, warm fetch, stall, redirect, conflict and reset.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;

    int n_checks;
    int n_errors;
    bit cmp_en;
    bit auto_ack;

    fetch_stage #(
        .ADDRESS_WIDTH (32),
        .CACHE_LINES   (16),
        .RESET_PC      (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .valid_o       (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: distinct word per address, addi-shaped.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[19:0], 12'h013};
    endfunction

    // Reference model: caches full line addresses, tracks "refill pending".
    logic        m_refill;
    logic [31:0] m_pc;
    logic [31:0] m_req_addr;
    logic [31:0] m_instr;
    logic [31:0] m_pc_o;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_line_v [16];
    logic [31:0] m_line_a [16];
    logic [31:0] m_line_d [16];
    logic [3:0]  m_idx;
    logic        m_hit;

    assign m_idx = m_pc[5:2];
    assign m_hit = m_line_v[m_idx] && (m_line_a[m_idx] == m_pc);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_refill   <= 1'b0;
            m_pc       <= 32'h0;
            m_req_addr <= 32'h0;
            m_instr    <= NOP_INSTR;
            m_pc_o     <= 32'h0;
            m_pc4      <= 32'h0;
            m_valid    <= 1'b0;
            for (int i = 0; i < 16; i++) m_line_v[i] <= 1'b0;
        end else if (!m_refill) begin
            if (redirect_i || (!stall_i && !m_hit)) begin
                m_valid <= 1'b0;
                m_instr <= NOP_INSTR;
            end else if (!stall_i) begin
                m_valid <= 1'b1;
                m_instr <= m_line_d[m_idx];
                m_pc_o  <= m_pc;
                m_pc4   <= m_pc + 32'd4;
            end
            if (redirect_i)              m_pc <= {redirect_pc_i[31:2], 2'b00};
            else if (m_hit && !stall_i)  m_pc <= m_pc + 32'd4;
            if (!m_hit) begin
                m_refill   <= 1'b1;
                m_req_addr <= m_pc;
            end
        end else begin
            if (redirect_i || !stall_i) begin
                m_valid <= 1'b0;
                m_instr <= NOP_INSTR;
            end
            if (redirect_i) m_pc <= {redirect_pc_i[31:2], 2'b00};
            if (mem_ack_i) begin
                m_line_v[m_req_addr[5:2]] <= 1'b1;
                m_line_a[m_req_addr[5:2]] <= m_req_addr;
                m_line_d[m_req_addr[5:2]] <= mem_rdata_i;
                m_refill                  <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_ifid(input string name, input logic v, input logic [31:0] ins,
                              input logic [31:0] pc);
        check({name, ".valid"}, 32'(valid_o), 32'(v));
        check({name, ".instr"}, instr_o, ins);
        if (v) begin
            check({name, ".pc"}, pc_o, pc);
            check({name, ".pc4"}, pc_plus4_o, pc + 32'd4);
        end
    endtask

    task automatic check_req(input string name, input logic req, input logic [31:0] addr);
        check({name, ".req"}, 32'(mem_req_o), 32'(req));
        if (req) check({name, ".addr"}, mem_addr_o, addr);
    endtask

    // One clock; memory answers a pending request in the following cycle when enabled.
    task automatic step();
        @(posedge clk);
        #1;
        if (auto_ack && mem_req_o) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = mem_word(mem_addr_o);
        end else begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hDEAD_BEEF;
        end
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_i    = 1'b1;
        redirect_pc_i = target;
        step();
        redirect_i    = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        cmp_en        = 1'b0;
        auto_ack      = 1'b1;
        rst_n         = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        mem_ack_i     = 1'b0;
        mem_rdata_i   = 32'hDEAD_BEEF;

        fork
            forever begin
                @(negedge clk);
                if (cmp_en && rst_n) begin
                    check("model.req", 32'(mem_req_o), 32'(m_refill));
                    check("model.addr", mem_addr_o, m_req_addr);
                    check("model.valid", 32'(valid_o), 32'(m_valid));
                    check("model.instr", instr_o, m_instr);
                    if (m_valid) begin
                        check("model.pc", pc_o, m_pc_o);
                        check("model.pc4", pc_plus4_o, m_pc4);
                    end
                end
            end
        join_none

        step();
        step();
        check("reset.req", 32'(mem_req_o), 32'h0);
        check("reset.addr", mem_addr_o, 32'h0);
        check("reset.valid", 32'(valid_o), 32'h0);
        check("reset.instr", instr_o, NOP_INSTR);
        check("reset.pc", pc_o, 32'h0);
        check("reset.pc4", pc_plus4_o, 32'h0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Cold start: miss at 0, one-cycle refill, re-lookup, valid two cycles after ack.
        step(); check_req("cold.req", 1'b1, 32'h0);
        step();
        step(); check_ifid("cold.out", 1'b1, 32'h0050_0093, 32'h0);
        step(); step(); step(); check_ifid("fill4", 1'b1, mem_word(32'h4), 32'h4);
        step(); step(); step(); check_ifid("fill8", 1'b1, mem_word(32'h8), 32'h8);
        step(); check_req("missC", 1'b1, 32'hC);
        redirect_to(32'h0);

        // Warm sequential refetch from 0.
        step(); check_ifid("warm0", 1'b1, 32'h0050_0093, 32'h0); check_req("warm0", 1'b0, 32'h0);
        step(); check_ifid("warm4", 1'b1, mem_word(32'h4), 32'h4); check_req("warm4", 1'b0, 32'h0);
        step(); check_ifid("warm8", 1'b1, mem_word(32'h8), 32'h8); check_req("warm8", 1'b0, 32'h0);

        // Redirect on a hit squashes it; then stall for two cycles with pc_o = 4.
        redirect_to(32'h0); check_ifid("squash", 1'b0, NOP_INSTR, 32'h0);
        step(); check_ifid("re0", 1'b1, 32'h0050_0093, 32'h0);
        step(); check_ifid("re4", 1'b1, mem_word(32'h4), 32'h4);
        stall_i = 1'b1;
        step(); check_ifid("stall1", 1'b1, mem_word(32'h4), 32'h4);
        step(); check_ifid("stall2", 1'b1, mem_word(32'h4), 32'h4);
        stall_i = 1'b0;
        step(); check_ifid("unstall", 1'b1, mem_word(32'h8), 32'h8);

        // Reset while a refill of 0x10 is outstanding.
        auto_ack = 1'b0;
        step(); check_ifid("pcC", 1'b1, mem_word(32'hC), 32'hC);
        step(); check_req("miss10", 1'b1, 32'h10);
        step();
        rst_n = 1'b0;
        #1;
        check("midrst.req", 32'(mem_req_o), 32'h0);
        check("midrst.valid", 32'(valid_o), 32'h0);
        step();
        rst_n = 1'b1;
        step(); check_req("restart", 1'b1, 32'h0);

        // Redirect to 0x40 (low bits ignored) while the refill of 0 is pending.
        step();
        auto_ack = 1'b1;
        redirect_to(32'h0000_0043); check_ifid("redir_refill", 1'b0, NOP_INSTR, 32'h0);
        step();
        step(); check_req("next_req", 1'b1, 32'h40);

        // 0x00 and 0x40 share index 0: redirecting between them misses every time.
        for (int i = 0; i < 4; i++) begin
            logic [31:0] tgt;
            tgt = (i % 2 == 0) ? 32'h0 : 32'h40;
            redirect_to(tgt);
            step();
            check_req("conflict", 1'b1, tgt);
            check("conflict.valid", 32'(valid_o), 32'h0);
        end
        step();
        step(); check_ifid("conflict_end", 1'b1, mem_word(32'h40), 32'h40);
        repeat (4) step();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
